// File: rtl/branch_redirect_pkg.sv
// Shared definitions for the branch redirect block: FSM state encodings and
// the default offset scaling (word offset to byte offset).
package branch_redirect_pkg;

   typedef enum logic {
      REDIR_IDLE   = 1'b0,
      REDIR_ACTIVE = 1'b1
   } redirState_t;

   localparam int OFFSET_SHIFT_DEF = 2;

endpackage

// File: rtl/branch_redirect_if.sv
// ID-to-fetch redirect bundle. The slave side is the redirect block; the
// master side is ID plus the consumers (PC mux, IF/ID, ID/EX). BRANCH_STATS_EN adds counters.
interface branch_redirect_if #(parameter int ADDR_W = 32);
   logic              brCond;
   logic              idValid;
   logic              freeze;
   logic [ADDR_W-1:0] idPcPlus4;
   logic [ADDR_W-1:0] idOffset;
   logic              redirectValid;
   logic [ADDR_W-1:0] redirectPC;
   logic              flushIFID;
   logic              killID;
   logic              busy;
`ifdef BRANCH_STATS_EN
   logic [31:0]       takenCount;
   logic [31:0]       squashCount;
`endif

   modport master (
      output brCond, idValid, freeze, idPcPlus4, idOffset,
      input  redirectValid, redirectPC, flushIFID, killID, busy
`ifdef BRANCH_STATS_EN
      , input takenCount, squashCount
`endif
   );

   modport slave (
      input  brCond, idValid, freeze, idPcPlus4, idOffset,
      output redirectValid, redirectPC, flushIFID, killID, busy
`ifdef BRANCH_STATS_EN
      , output takenCount, squashCount
`endif
   );
endinterface

// File: rtl/branch_redirect_target_adder.sv
// Combinational branch/jump target: pcPlus4 + (offset << SHIFT), wrapping
// modulo 2^ADDR_W.
module branchTargetAdder #(
   parameter int ADDR_W = 32,
   parameter int SHIFT  = 2
) (
   input  logic [ADDR_W-1:0] pcPlus4,
   input  logic [ADDR_W-1:0] offset,
   output logic [ADDR_W-1:0] target
);
   assign target = pcPlus4 + (offset << SHIFT);
endmodule

// File: rtl/branch_redirect.sv
// Registered branch resolution: turns a taken decision in ID into a one-shot
// PC redirect plus IF/ID flush and ID kill, held across freezes.
// Optional BRANCH_STATS_EN adds saturating taken/squash counters.
module branch_redirect
   import branch_redirect_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int OFFSET_SHIFT = OFFSET_SHIFT_DEF
) (
   input logic              clk,
   input logic              rst,
   branch_redirect_if.slave bus
);

   redirState_t       state, nextState;
   logic [ADDR_W-1:0] targetQ;
   logic [ADDR_W-1:0] targetD;
   logic              capture;
   logic              release_;

   branchTargetAdder #(.ADDR_W(ADDR_W), .SHIFT(OFFSET_SHIFT)) uAdder (
      .pcPlus4 (bus.idPcPlus4),
      .offset  (bus.idOffset),
      .target  (targetD)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= REDIR_IDLE;
         targetQ <= '0;
      end else begin
         state <= nextState;
         if (capture) targetQ <= targetD;
      end
   end

   // Capture is deferred while frozen: ID operands may still be stale.
   always_comb begin
      nextState = state;
      capture   = 1'b0;
      release_  = 1'b0;
      case (state)
         REDIR_IDLE: begin
            if (bus.idValid && bus.brCond && !bus.freeze) begin
               nextState = REDIR_ACTIVE;
               capture   = 1'b1;
            end
         end
         REDIR_ACTIVE: begin
            if (!bus.freeze) begin
               nextState = REDIR_IDLE;
               release_  = 1'b1;
            end
         end
         default: nextState = REDIR_IDLE;
      endcase
   end

   assign bus.busy          = (state == REDIR_ACTIVE);
   assign bus.redirectValid = bus.busy;
   assign bus.flushIFID     = bus.busy;
   assign bus.killID        = bus.busy;
   assign bus.redirectPC    = bus.busy ? targetQ : '0;

`ifdef BRANCH_STATS_EN
   logic [31:0] takenQ, squashQ;

   always_ff @(posedge clk) begin
      if (rst) begin
         takenQ  <= '0;
         squashQ <= '0;
      end else begin
         if (capture && takenQ != 32'hFFFF_FFFF) takenQ <= takenQ + 32'd1;
         if (release_) squashQ <= (squashQ >= 32'hFFFF_FFFD) ? 32'hFFFF_FFFF : squashQ + 32'd2;
      end
   end

   assign bus.takenCount  = takenQ;
   assign bus.squashCount = squashQ;
`else
   logic unusedRelease;
   assign unusedRelease = release_;
`endif

endmodule
